// File: rtl/soc_bram_burst_ctl.sv
// Byte-addressed BRAM controller: LANES 8-bit BRAMs, sized big-endian accesses,
// auto-incrementing wrapping bursts and an oversize-request error response.

module soc_bram_burst_ctl #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LEN_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [addr_width-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic [LEN_W-1:0]      i_len,
    input  logic                  i_rw,
    input  logic                  i_stb,
    input  logic [8*LANES-1:0]    i_dwrite,
    output logic [8*LANES-1:0]    o_dread,
    output logic                  o_ack,
    output logic                  o_err,
    output logic                  o_busy
);
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned ROW_W = addr_width - OFF_W;
    localparam int unsigned DW    = 8 * LANES;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [addr_width-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_rw;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_busy;

    logic                  w_bad;
    logic                  w_issue;
    logic [addr_width-1:0] w_beat_addr;
    logic [1:0]            w_beat_size;
    logic                  w_beat_rw;
    logic [OFF_W-1:0]      w_off;
    logic [ROW_W-1:0]      w_row0;
    logic [OFF_W-1:0]      w_nm1;
    logic [OFF_W-1:0]      w_j   [LANES];
    logic [OFF_W-1:0]      w_k   [LANES];
    logic [LANES-1:0]      w_en;
    logic [LANES-1:0]      w_we;
    logic [ROW_W-1:0]      w_row [LANES];
    logic [7:0]            w_din [LANES];
    logic [7:0]            w_dout[LANES];
    logic [OFF_W-1:0]      w_roff;
    logic [OFF_W-1:0]      w_rnm1;
    logic [OFF_W-1:0]      w_rk  [LANES];
    logic [DW-1:0]         w_rdata;

    // Requests wider than the bus are accepted but answered with an error.
    assign w_bad = (32'(1) << i_size) > 32'(LANES);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_stb) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = (r_cnt == '0 || r_err) ? S_IDLE : S_ISSUE;
            S_ISSUE: w_state_nxt = S_ACK;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat issue: beat 0 bypasses the registers so it reaches the BRAMs at accept
    always_comb begin
        w_issue     = 1'b0;
        w_beat_addr = r_addr;
        w_beat_size = r_size;
        w_beat_rw   = r_rw;
        case (r_state)
            S_IDLE: begin
                w_issue     = i_stb & ~w_bad;
                w_beat_addr = i_addr;
                w_beat_size = i_size;
                w_beat_rw   = i_rw;
            end
            S_ISSUE: w_issue = 1'b1;
            default: w_issue = 1'b0;
        endcase
    end

    assign w_off  = w_beat_addr[OFF_W-1:0];
    assign w_row0 = w_beat_addr[addr_width-1:OFF_W];
    assign w_nm1  = OFF_W'((32'(1) << w_beat_size) - 32'(1));

    // Lane l carries byte j = (l - offset) mod LANES; lanes below the offset sit one row up
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_j[l]   = OFF_W'(l) - w_off;
            w_k[l]   = w_nm1 - w_j[l];
            w_en[l]  = w_issue && (32'(w_j[l]) < (32'(1) << w_beat_size));
            w_we[l]  = w_en[l] && w_beat_rw && i_reset_n;
            w_row[l] = (OFF_W'(l) < w_off) ? w_row0 + ROW_W'(1) : w_row0;
            w_din[l] = i_dwrite[8*w_k[l] +: 8];
        end
    end

    // One 8-bit BRAM per lane; contents are intentionally not reset
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] r_mem [0:(2**ROW_W)-1];
        logic [7:0] r_dout;

        always_ff @(posedge i_clk) begin
            if (w_en[g]) begin
                if (w_we[g]) r_mem[w_row[g]] <= w_din[g];
                r_dout <= r_mem[w_row[g]];
            end
        end

        assign w_dout[g] = r_dout;
    end

    // Transaction registers and registered status outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr <= '0;
            r_size <= '0;
            r_rw   <= 1'b0;
            r_cnt  <= '0;
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ack  <= (w_state_nxt == S_ACK);
            r_busy <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && i_stb) begin
                r_addr <= i_addr;
                r_size <= i_size;
                r_rw   <= i_rw;
                r_cnt  <= i_len;
                r_err  <= w_bad;
            end else if (r_state == S_ACK) begin
                if (w_state_nxt == S_ISSUE) begin
                    r_cnt  <= r_cnt - LEN_W'(1);
                    r_addr <= r_addr + addr_width'(32'(1) << r_size);
                end else begin
                    r_err <= 1'b0;
                end
            end
        end
    end

    assign w_roff = r_addr[OFF_W-1:0];
    assign w_rnm1 = OFF_W'((32'(1) << r_size) - 32'(1));

    // Read path: rotate lane outputs by the beat offset, right-justify, zero-extend
    always_comb begin
        w_rdata = '0;
        for (int j = 0; j < LANES; j++) begin
            w_rk[j] = w_rnm1 - OFF_W'(j);
            if (32'(j) < (32'(1) << r_size)) begin
                w_rdata[8*w_rk[j] +: 8] = w_dout[OFF_W'(OFF_W'(j) + w_roff)];
            end
        end
    end

    assign o_dread = (r_ack && !r_err) ? w_rdata : '0;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_soc_bram_burst_ctl.sv
// Self-checking bench for soc_bram_burst_ctl: directed plan items plus random
// bursts checked against a byte-array memory model.

module tb_soc_bram_burst_ctl;
    localparam int unsigned AW    = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned LEN_W = 4;

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     i_addr;
    logic [1:0]        i_size;
    logic [LEN_W-1:0]  i_len;
    logic              i_rw;
    logic              i_stb;
    logic [31:0]       i_dwrite;
    logic [31:0]       o_dread;
    logic              o_ack;
    logic              o_err;
    logic              o_busy;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [31:0]       wdat [16];
    logic [7:0]        mem  [256];
    bit                kn   [256];
    logic [31:0]       rd;
    int                bc;

    soc_bram_burst_ctl #(
        .addr_width(AW),
        .LANES     (LANES),
        .LEN_W     (LEN_W)
    ) u_dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_addr   (i_addr),
        .i_size   (i_size),
        .i_len    (i_len),
        .i_rw     (i_rw),
        .i_stb    (i_stb),
        .i_dwrite (i_dwrite),
        .o_dread  (o_dread),
        .o_ack    (o_ack),
        .o_err    (o_err),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Big-endian model: byte a+j is the j-th most significant of the n bytes
    function automatic logic [31:0] mdl_rd(input logic [7:0] a, input int n, output bit ok);
        logic [31:0] v;
        logic [7:0]  ad;
        v  = '0;
        ok = 1'b1;
        for (int j = 0; j < n; j++) begin
            ad = a + 8'(j);
            ok = ok & kn[ad];
            v  = (v << 8) | 32'(mem[ad]);
        end
        return v;
    endfunction

    function automatic void mdl_wr(input logic [7:0] a, input int n, input logic [31:0] d);
        logic [7:0] ad;
        for (int j = 0; j < n; j++) begin
            ad      = a + 8'(j);
            mem[ad] = d[8*(n-1-j) +: 8];
            kn[ad]  = 1'b1;
        end
    endfunction

    // Request-side inputs are don't-care while busy
    task automatic scramble();
        i_stb  = 1'($urandom);
        i_addr = 8'($urandom);
        i_size = 2'($urandom);
        i_len  = 4'($urandom);
        i_rw   = 1'($urandom);
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the idle cycle after the last ack
    task automatic run_txn(input logic [7:0] a, input logic [1:0] sz, input logic [3:0] len,
                           input logic rw, output logic [31:0] last_rd, output int busy_cyc);
        int          n;
        int          beats;
        bit          bad;
        bit          ok;
        logic [7:0]  b;
        logic [31:0] exp;
        n        = 1 << sz;
        bad      = (n > 4);
        beats    = bad ? 1 : int'(len) + 1;
        busy_cyc = 0;
        last_rd  = '0;
        b        = a;
        i_addr   = a;
        i_size   = sz;
        i_len    = len;
        i_rw     = rw;
        i_stb    = 1'b1;
        i_dwrite = wdat[0];
        for (int k = 0; k < beats; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (o_busy) busy_cyc++;
                chk("issue_ack", 32'(o_ack), 32'd0);
                chk("issue_busy", 32'(o_busy), 32'd1);
                scramble();
            end
            @(posedge clk);
            @(negedge clk);
            if (o_busy) busy_cyc++;
            chk("ack", 32'(o_ack), 32'd1);
            chk("ack_busy", 32'(o_busy), 32'd1);
            chk("ack_err", 32'(o_err), 32'(bad));
            if (bad) begin
                chk("err_dread", o_dread, 32'd0);
            end else if (rw) begin
                mdl_wr(b, n, wdat[k]);
            end else begin
                exp = mdl_rd(b, n, ok);
                if (ok) chk("rdata", o_dread, exp);
                last_rd = o_dread;
            end
            b = b + 8'(n);
            scramble();
            if (k + 1 < beats) i_dwrite = wdat[k+1];
        end
        i_stb = 1'b0;
        @(negedge clk);
        chk("idle_ack", 32'(o_ack), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_addr   = '0;
        i_size   = '0;
        i_len    = '0;
        i_rw     = 1'b0;
        i_stb    = 1'b0;
        i_dwrite = '0;
        for (int k = 0; k < 16; k++) wdat[k] = '0;

        // Reset, then a read with one-cycle ack latency, then async reset between edges
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst_n  = 1'b1;
        i_addr = 8'h00;
        i_size = 2'd2;
        i_len  = '0;
        i_rw   = 1'b0;
        i_stb  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_stb = 1'b0;
        chk("t1_ack", 32'(o_ack), 32'd1);
        chk("t1_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_ack", 32'(o_ack), 32'd0);
        chk("t1_async_busy", 32'(o_busy), 32'd0);
        chk("t1_async_err", 32'(o_err), 32'd0);
        chk("t1_async_dread", o_dread, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole memory with word bursts so every later read is predictable
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) wdat[k] = $urandom;
            run_txn(8'(blk * 64), 2'd2, 4'd15, 1'b1, rd, bc);
            chk("fill_busy", 32'(bc), 32'd31);
        end

        // Aligned word
        wdat[0] = 32'h11223344;
        run_txn(8'h04, 2'd2, 4'd0, 1'b1, rd, bc);
        run_txn(8'h04, 2'd2, 4'd0, 1'b0, rd, bc);
        chk("t2_word", rd, 32'h11223344);
        run_txn(8'h06, 2'd0, 4'd0, 1'b0, rd, bc);
        chk("t2_byte", rd, 32'h00000033);

        // Unaligned across rows
        wdat[0] = 32'hAABBCCDD;
        run_txn(8'h00, 2'd2, 4'd0, 1'b1, rd, bc);
        wdat[0] = 32'h01020304;
        run_txn(8'h04, 2'd2, 4'd0, 1'b1, rd, bc);
        run_txn(8'h03, 2'd2, 4'd0, 1'b0, rd, bc);
        chk("t3_word", rd, 32'hDD010203);
        run_txn(8'h07, 2'd1, 4'd0, 1'b0, rd, bc);
        chk("t3_half_first", 32'(rd[15:8]), 32'h04);
        chk("t3_half_zext", 32'(rd[31:16]), 32'h0);

        // Wrapping halfword burst
        wdat[0] = 32'h1111;
        wdat[1] = 32'h2222;
        wdat[2] = 32'h3333;
        wdat[3] = 32'h4444;
        run_txn(8'hFE, 2'd1, 4'd3, 1'b1, rd, bc);
        chk("t4_busy", 32'(bc), 32'd7);
        run_txn(8'h00, 2'd2, 4'd0, 1'b0, rd, bc);
        chk("t4_word", rd, 32'h22223333);
        run_txn(8'hFE, 2'd1, 4'd0, 1'b0, rd, bc);
        chk("t4_half", rd, 32'h00001111);

        // Oversize request
        wdat[0] = $urandom;
        run_txn(8'h04, 2'd3, 4'd5, 1'b1, rd, bc);
        chk("t5_busy", 32'(bc), 32'd1);
        run_txn(8'h04, 2'd2, 4'd0, 1'b0, rd, bc);
        chk("t5_old", rd, 32'h44440304);

        // Random bursts against the model
        for (int t = 0; t < 200; t++) begin
            logic [1:0] sz;
            for (int k = 0; k < 16; k++) wdat[k] = $urandom;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_txn(8'($urandom), sz, 4'($urandom), 1'($urandom), rd, bc);
        end

        // Reset during the issue cycle of beat 2 of a 4-beat write
        for (int k = 0; k < 4; k++) wdat[k] = $urandom;
        i_addr   = 8'h10;
        i_size   = 2'd2;
        i_len    = 4'd3;
        i_rw     = 1'b1;
        i_stb    = 1'b1;
        i_dwrite = wdat[0];
        @(posedge clk);
        @(negedge clk);
        i_stb = 1'b0;
        chk("rb_ack0", 32'(o_ack), 32'd1);
        mdl_wr(8'h10, 4, wdat[0]);
        i_dwrite = wdat[1];
        @(negedge clk);
        chk("rb_issue1", 32'(o_busy), 32'd1);
        @(negedge clk);
        chk("rb_ack1", 32'(o_ack), 32'd1);
        mdl_wr(8'h14, 4, wdat[1]);
        i_dwrite = wdat[2];
        @(negedge clk);
        chk("rb_issue2", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        i_stb  = 1'b1;
        i_rw   = 1'b1;
        i_addr = 8'h18;
        i_size = 2'd2;
        #1;
        chk("rb_ack", 32'(o_ack), 32'd0);
        chk("rb_busy", 32'(o_busy), 32'd0);
        chk("rb_err", 32'(o_err), 32'd0);
        chk("rb_dread", o_dread, 32'd0);
        @(negedge clk);
        @(negedge clk);
        i_stb = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_txn(8'(8'h10 + 8'(4 * k)), 2'd2, 4'd0, 1'b0, rd, bc);
        end
        run_txn(8'h10, 2'd2, 4'd0, 1'b0, rd, bc);
        chk("rb_beat0", rd, wdat[0]);
        run_txn(8'h14, 2'd2, 4'd0, 1'b0, rd, bc);
        chk("rb_beat1", rd, wdat[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
